// File: rtl/bitand_cosim_driver.sv
`default_nettype none
// ============================================================================
// bitand_cosim_driver : LFSR stimulus generator and response checker for a
// 128-bit reduction-AND unit under test.
// Revision: 1.0
// ============================================================================
module bitand_cosim_driver #(
   parameter int RESP_LAT = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [31:0]  seed,
   input  logic [15:0]  num_vecs,
   output logic [127:0] dut_in,
   input  logic [127:0] dut_out,
   output logic         busy,
   output logic         done,
   output logic         pass,
   output logic [15:0]  err_count,
   output logic [15:0]  first_err_idx
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DRIVE = 3'd1,
      WAIT  = 3'd2,
      CHECK = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [31:0]  C_TAPS      = 32'h8020_0003;
   localparam int           C_WAIT_INIT = (RESP_LAT > 1) ? RESP_LAT - 2 : 0;
   localparam logic [3:0]   C_WAIT_LOAD = 4'(C_WAIT_INIT);
   localparam logic [127:0] C_HI_MASK   = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFC0_0000_0000;

   state_t         state_q, state_d;
   logic [31:0]    lfsr_q, lfsr_d;
   logic [15:0]    idx_q, idx_d;
   logic [15:0]    num_vecs_q, num_vecs_d;
   logic [15:0]    err_count_q, err_count_d;
   logic [15:0]    first_err_idx_q, first_err_idx_d;
   logic [127:0]   dut_in_q, dut_in_d;
   logic [3:0]     wait_cnt_q, wait_cnt_d;

   logic [31:0]    lfsr_s0, lfsr_s1, lfsr_s2, lfsr_s3;
   logic [127:0]   stim;
   logic [127:0]   exp_out;
   logic           mismatch;

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ C_TAPS) : (s >> 1);
   endfunction

   // Each output field carries the AND-reduction in its LSB only; upper bits stay zero.
   function automatic logic [127:0] expect_out(input logic [127:38] v);
      logic [127:0] e;
      e        = '0;
      e[0]     = v[83];
      e[1]     = &v[85:84];
      e[3]     = &v[88:86];
      e[6]     = &v[92:89];
      e[10]    = &v[97:93];
      e[15]    = &v[103:98];
      e[21]    = &v[110:104];
      e[28]    = &v[118:111];
      e[36]    = &v[127:119];
      e[45]    = v[38];
      e[46]    = &v[40:39];
      e[48]    = &v[43:41];
      e[51]    = &v[47:44];
      e[55]    = &v[52:48];
      e[60]    = &v[58:53];
      e[66]    = &v[65:59];
      e[73]    = &v[73:66];
      e[81]    = &v[82:74];
      e[90]    = &v[127:119];
      e[96]    = &v[127:119];
      e[102]   = &v[88:86];
      e[108]   = &v[43:41];
      e[114]   = v[83];
      e[120]   = v[38];
      return e;
   endfunction

   // S0 is the first state after the current one; the register ends a DRIVE on S3.
   always_comb begin
      lfsr_s0 = lfsr_step(lfsr_q);
      lfsr_s1 = lfsr_step(lfsr_s0);
      lfsr_s2 = lfsr_step(lfsr_s1);
      lfsr_s3 = lfsr_step(lfsr_s2);
      stim    = {lfsr_s3, lfsr_s2, lfsr_s1, lfsr_s0};
      unique case (idx_q[1:0])
         2'd0:    stim = {lfsr_s3, lfsr_s2, lfsr_s1, lfsr_s0};
         2'd1:    stim = '1;
         2'd2:    stim = ~(128'd1 << lfsr_s0[6:0]);
         default: stim = {lfsr_s3, lfsr_s2, lfsr_s1, lfsr_s0} | C_HI_MASK;
      endcase
   end

   assign exp_out  = expect_out(dut_in_q[127:38]);
   assign mismatch = (dut_out != exp_out);

   always_comb begin
      state_d         = state_q;
      lfsr_d          = lfsr_q;
      idx_d           = idx_q;
      num_vecs_d      = num_vecs_q;
      err_count_d     = err_count_q;
      first_err_idx_d = first_err_idx_q;
      dut_in_d        = dut_in_q;
      wait_cnt_d      = wait_cnt_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               lfsr_d          = (seed == 32'd0) ? 32'd1 : seed;
               num_vecs_d      = num_vecs;
               idx_d           = 16'd0;
               err_count_d     = 16'd0;
               first_err_idx_d = 16'hFFFF;
               state_d         = (num_vecs == 16'd0) ? DONE : DRIVE;
            end
         end
         DRIVE: begin
            dut_in_d   = stim;
            lfsr_d     = lfsr_s3;
            wait_cnt_d = C_WAIT_LOAD;
            state_d    = (RESP_LAT > 1) ? WAIT : CHECK;
         end
         WAIT: begin
            if (wait_cnt_q == 4'd0) begin
               state_d = CHECK;
            end else begin
               wait_cnt_d = wait_cnt_q - 4'd1;
            end
         end
         CHECK: begin
            if (mismatch) begin
               if (err_count_q != 16'hFFFF) begin
                  err_count_d = err_count_q + 16'd1;
               end
               if (first_err_idx_q == 16'hFFFF) begin
                  first_err_idx_d = idx_q;
               end
            end
            // Widened compare so num_vecs=FFFF terminates instead of wrapping idx.
            if (({1'b0, idx_q} + 17'd1) < {1'b0, num_vecs_q}) begin
               idx_d   = idx_q + 16'd1;
               state_d = DRIVE;
            end else begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         lfsr_q          <= 32'd1;
         idx_q           <= 16'd0;
         num_vecs_q      <= 16'd0;
         err_count_q     <= 16'd0;
         first_err_idx_q <= 16'hFFFF;
         dut_in_q        <= '0;
         wait_cnt_q      <= 4'd0;
      end else begin
         state_q         <= state_d;
         lfsr_q          <= lfsr_d;
         idx_q           <= idx_d;
         num_vecs_q      <= num_vecs_d;
         err_count_q     <= err_count_d;
         first_err_idx_q <= first_err_idx_d;
         dut_in_q        <= dut_in_d;
         wait_cnt_q      <= wait_cnt_d;
      end
   end

   assign dut_in        = dut_in_q;
   assign busy          = (state_q == DRIVE) || (state_q == WAIT) || (state_q == CHECK);
   assign done          = (state_q == DONE);
   assign pass          = (state_q == DONE) && (err_count_q == 16'd0);
   assign err_count     = err_count_q;
   assign first_err_idx = first_err_idx_q;

endmodule
`default_nettype wire

// File: doc/bitand_cosim_driver.md
BITAND_COSIM_DRIVER -- requirements
Module: bitand_cosim_driver

Interface
REQ-001 Parameter RESP_LAT, default 1: number of cycles from a dut_in update to the dut_out sample; legal range 0..15.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  one-cycle pulse that begins a run; ignored unless the FSM is in IDLE or DONE.
REQ-005 seed  input  32  initial LFSR state, captured on an accepted start; a value of 0 SHALL be replaced by 32'h1.
REQ-006 num_vecs  input  16  number of vectors in the run, captured on an accepted start; 0 SHALL produce an immediate DONE with pass=1.
REQ-007 dut_in  output  128  registered stimulus driven to the reduction-AND unit under test.
REQ-008 dut_out  input  128  response from the unit under test.
REQ-009 busy  output  1  high while the FSM is in DRIVE, WAIT or CHECK.
REQ-010 done  output  1  high while the FSM is in DONE.
REQ-011 pass  output  1  high in DONE when err_count==0; low in every other state.
REQ-012 err_count  output  16  number of mismatching vectors; saturates at 16'hFFFF.
REQ-013 first_err_idx  output  16  index of the first mismatching vector; holds 16'hFFFF until a mismatch occurs.

Function
REQ-014 FSM states SHALL be IDLE, DRIVE, WAIT, CHECK and DONE.
REQ-015 Transitions:
- IDLE/DONE on accepted start -> DRIVE; if num_vecs==0, -> DONE instead.
- DRIVE -> WAIT if RESP_LAT>1, otherwise -> CHECK.
- WAIT -> CHECK after RESP_LAT-1 cycles.
- CHECK -> DRIVE if idx+1<num_vecs, otherwise -> DONE.
REQ-016 With RESP_LAT=0, CHECK SHALL sample dut_out combinationally in the same cycle that dut_in is valid; the DRIVE register update and the CHECK compare then share one vector slot of 2 cycles.
REQ-017 On an accepted start, the block SHALL clear idx, err_count and pass, set first_err_idx to FFFF, and load the LFSR.
REQ-018 LFSR: 32-bit Galois, taps 0x80200003, advanced 4 times per DRIVE cycle; the four successive states S0..S3 SHALL be concatenated as R={S3,S2,S1,S0}.
REQ-019 Stimulus by idx[1:0]:
- 0: R.
- 1: all ones.
- 2: all ones with bit (S0 mod 128) cleared.
- 3: R OR 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFC0_0000_0000.
REQ-020 Input field map on dut_in:
- a9[127:119] a8[118:111] a7[110:104] a6[103:98] a5[97:93] a4[92:89] a3[88:86] a2[85:84] a1[83]
- b9[82:74] b8[73:66] b7[65:59] b6[58:53] b5[52:48] b4[47:44] b3[43:41] b2[40:39] b1[38]
- [37:0] unused.
REQ-021 Expected output fields, each equal to the 1-bit AND-reduction of its source zero-extended to the field width (signedness of the source SHALL NOT cause sign extension):
- oa1[0] oa2[2:1] oa3[5:3] oa4[9:6] oa5[14:10] oa6[20:15] oa7[27:21] oa8[35:28] oa9[44:36] (sources a1..a9)
- ob1[45] ob2[47:46] ob3[50:48] ob4[54:51] ob5[59:55] ob6[65:60] ob7[72:66] ob8[80:73] ob9[89:81] (sources b1..b9)
- oc1[95:90]=&a9, oc2[101:96]=&a9, oc3[107:102]=&a3, oc4[113:108]=&b3, oc5[119:114]=&a1, oc6[125:120]=&b1
- bits [127:126]=0.
REQ-022 In CHECK, any bit mismatch between dut_out and the expected value SHALL increment err_count (saturating) and, if first_err_idx==FFFF, load first_err_idx with idx.
REQ-023 dut_in SHALL hold its value in WAIT, CHECK and DONE.
REQ-024 A start pulse while busy SHALL be ignored.
REQ-025 idx SHALL be 16 bits; num_vecs=FFFF SHALL complete without wrap-around.

Reset
REQ-026 When rst is high, the block SHALL enter IDLE and set dut_in=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=FFFF, idx=0 and LFSR=1 on the next edge.
REQ-027 rst SHALL take priority over start in the same cycle.
REQ-028 rst asserted mid-run SHALL abort the run with no DONE and no pass.

Verification
REQ-029 Ideal model connected, seed=1, num_vecs=8, RESP_LAT=1 -> done after 16 cycles, pass=1, err_count=0, first_err_idx=FFFF.
REQ-030 Vector idx=1 (all ones) into the ideal model -> expected value 126'h..., with every field equal to 1 in its LSB and bits [127:126]=0; e.g. oc4=6'b000001 (no sign extension).
REQ-031 Model with dut_out[125:120] stuck at 6'h3F, num_vecs=4 -> err_count=4, first_err_idx=0, pass=0.
REQ-032 num_vecs=0 -> done one cycle after start, pass=1, dut_in unchanged.
REQ-033 rst asserted during WAIT of vector 3 -> IDLE on the next edge, outputs at reset values, and a later start runs cleanly.
REQ-034 RESP_LAT=3 with a model delayed 3 cycles -> pass=1; the same model with RESP_LAT=2 -> err_count>0.
